// File: rtl/aes_mix_pkg.sv
// Shared types and GF(2^8) helpers for the AES MixColumns engine.
// Optional feature macro used by this slice: AES_MIXCOL_BYPASS_EN.
package aes_mix_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [31:0]  col_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mix_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b,
                                       input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        logic [7:0] r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'h1:    r = b;
            4'h2:    r = x2;
            4'h3:    r = x2 ^ b;
            4'h9:    r = x8 ^ b;
            4'hb:    r = x8 ^ x2 ^ b;
            4'hd:    r = x8 ^ x4 ^ b;
            4'he:    r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mixcolumn_unit.sv
// One-column MixColumns / InvMixColumns, purely combinational.
// Optional feature macro in this slice: AES_MIXCOL_BYPASS_EN (handled by the top).
module mixcolumn_unit
    import aes_mix_pkg::*;
(
    input  logic inv,
    input  col_t a,
    output col_t y
);

    logic [7:0] b [4];
    logic [3:0] c0, c1, c2, c3;

    assign c0 = inv ? 4'he : 4'h2;
    assign c1 = inv ? 4'hb : 4'h3;
    assign c2 = inv ? 4'hd : 4'h1;
    assign c3 = inv ? 4'h9 : 4'h1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            b[i] = a[31-8*i -: 8];
        end
    end

    // Row i uses the coefficient vector rotated right by i.
    always_comb begin
        y = '0;
        for (int i = 0; i < 4; i++) begin
            y[31-8*i -: 8] = gmul(b[2'(i)],     c0)
                           ^ gmul(b[2'(i + 1)], c1)
                           ^ gmul(b[2'(i + 2)], c2)
                           ^ gmul(b[2'(i + 3)], c3);
        end
    end

endmodule

// File: rtl/mixcolumns_seq.sv
// Iterative, handshaked MixColumns engine, COLS_PER_CYCLE columns per clock.
// Define AES_MIXCOL_BYPASS_EN to add in_bypass (pass-through for the final round).
module mixcolumns_seq
    import aes_mix_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit OUT_REG        = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
`ifdef AES_MIXCOL_BYPASS_EN
    input  logic         in_bypass,
`endif
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int NC = COLS_PER_CYCLE;
    localparam logic [1:0] STEP = 2'(NC);
    localparam logic [1:0] LAST = 2'(4 - NC);

    if (!(NC == 1 || NC == 2 || NC == 4)) begin : g_bad_cols
        $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mix_state_e st, st_nxt;
    logic [1:0] cnt;
    state_t     work, work_nxt;
    logic       inv_q, byp_q;
    logic       accept, last;
    col_t       cols [4];
    col_t       ucol [NC];
    col_t       uy   [NC];

    assign accept = in_valid && in_ready;
    assign last   = (cnt == LAST);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cols[i] = work[127-32*i -: 32];
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_unit
        assign ucol[g] = cols[cnt + 2'(g)];
        mixcolumn_unit u_mix (
            .inv (inv_q),
            .a   (ucol[g]),
            .y   (uy[g])
        );
    end

    // Column k lives at bits {~k, 5'h1f} -: 32.
    always_comb begin
        work_nxt = work;
        for (int g = 0; g < NC; g++) begin
            work_nxt[{~(cnt + 2'(g)), 5'h1f} -: 32] =
                byp_q ? ucol[g] : uy[g];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) st <= IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            IDLE:    if (accept) st_nxt = BUSY;
            BUSY:    if (last) st_nxt = DONE;
            DONE:    if (out_ready) st_nxt = in_valid ? BUSY : IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (st == IDLE) || (st == DONE && out_ready);
        out_valid = (st == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work  <= '0;
            cnt   <= '0;
            inv_q <= 1'b0;
        end else if (accept) begin
            work  <= in_state;
            cnt   <= '0;
            inv_q <= in_inv;
        end else if (st == BUSY) begin
            work  <= work_nxt;
            cnt   <= cnt + STEP;
        end
    end

`ifdef AES_MIXCOL_BYPASS_EN
    always_ff @(posedge clk) begin
        if (reset)       byp_q <= 1'b0;
        else if (accept) byp_q <= in_bypass;
    end
`else
    assign byp_q = 1'b0;
`endif

    if (OUT_REG) begin : g_oreg
        state_t out_q;
        always_ff @(posedge clk) begin
            if (reset)                  out_q <= '0;
            else if (st == BUSY && last) out_q <= work_nxt;
        end
        assign out_state = out_q;
    end else begin : g_owork
        assign out_state = work;
    end

endmodule
